// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcode, branch condition and flag-index definitions.
package cpu_pkg;
    localparam logic [2:0] ADD    = 3'b000;
    localparam logic [2:0] SUB    = 3'b001;
    localparam logic [2:0] RED    = 3'b010;
    localparam logic [2:0] XOR    = 3'b011;
    localparam logic [2:0] SLL    = 3'b100;
    localparam logic [2:0] SRA    = 3'b101;
    localparam logic [2:0] ROR    = 3'b110;
    localparam logic [2:0] PADDSB = 3'b111;

    localparam logic [2:0] NE     = 3'b000;
    localparam logic [2:0] EQ     = 3'b001;
    localparam logic [2:0] GT     = 3'b010;
    localparam logic [2:0] LT     = 3'b011;
    localparam logic [2:0] GE     = 3'b100;
    localparam logic [2:0] LE     = 3'b101;
    localparam logic [2:0] OV     = 3'b110;
    localparam logic [2:0] UNCOND = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    function automatic logic [2:0] flag_update_mask(input logic [2:0] op);
        return (op == ADD || op == SUB) ? 3'b111 :
               (op == RED || op == PADDSB) ? 3'b000 : 3'b010;
    endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational evaluation of a 3-bit branch condition against {N,Z,V}.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    logic n, z, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b1;
        case (cond)
            NE:      taken = !z;
            EQ:      taken = z;
            GT:      taken = !z && !n;
            LT:      taken = n;
            GE:      taken = z || !n;
            LE:      taken = n || z;
            OV:      taken = v;
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: flag register, branch condition resolve and registered B/BR target for fetch.
// Define FLAG_FWD_EN to bypass same-cycle ALU flags into branch evaluation.
module flag_branch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       alu_flag,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic             br_reg_mode,
    input  logic [PC_W-1:0]  pc_plus2,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [PC_W-1:0]  br_reg,
    input  logic             stall,
    input  logic             flush,
    output logic [2:0]       flags,
    output logic             br_out_valid,
    output logic             br_taken,
    output logic [PC_W-1:0]  br_target
);
    logic [2:0]      flags_q, flags_d, mask, eff_flags;
    logic            valid_q, taken_q, cond_true;
    logic [PC_W-1:0] target_q, target_d, imm_sext;

    always_comb begin
        mask      = flag_update_mask(alu_op);
        flags_d   = alu_valid ? ((flags_q & ~mask) | (alu_flag & mask)) : flags_q;
`ifdef FLAG_FWD_EN
        eff_flags = flags_d;
`else
        eff_flags = flags_q;
`endif
        imm_sext  = {{(PC_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
        target_d  = br_reg_mode ? br_reg : pc_plus2 + {imm_sext[PC_W-2:0], 1'b0};
    end

    branch_cond_eval u_cond (
        .cond  (br_cond),
        .flags (eff_flags),
        .taken (cond_true)
    );

    // flush beats stall; br_target is left untouched by a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q  <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
        end else if (!stall) begin
            flags_q  <= flags_d;
            valid_q  <= br_valid;
            taken_q  <= br_valid && cond_true;
            target_q <= br_valid ? target_d : target_q;
        end
    end

    assign flags        = flags_q;
    assign br_out_valid = valid_q;
    assign br_taken     = taken_q;
    assign br_target    = target_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed self-checking bench for flag_branch_unit (honours FLAG_FWD_EN).
module tb_flag_branch_unit;
    logic        clk = 1'b0;
    logic        rst, alu_valid, br_valid, br_reg_mode, stall, flush;
    logic [2:0]  alu_op, alu_flag, br_cond, flags;
    logic [15:0] pc_plus2, br_reg, br_target;
    logic [8:0]  br_imm;
    logic        br_out_valid, br_taken;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  tbl  [4];
    logic [2:0]  pats [4];
    logic        exp_fwd;

    always #5 clk = ~clk;

    flag_branch_unit #(.PC_W(16), .IMM_W(9)) dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_op(alu_op), .alu_flag(alu_flag),
        .br_valid(br_valid), .br_cond(br_cond), .br_reg_mode(br_reg_mode), .pc_plus2(pc_plus2),
        .br_imm(br_imm), .br_reg(br_reg), .stall(stall), .flush(flush), .flags(flags),
        .br_out_valid(br_out_valid), .br_taken(br_taken), .br_target(br_target)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 0; br_valid = 0; stall = 0; flush = 0;
    endtask

    initial begin
        // bit c of tbl[i] = expected taken for condition c with flags pats[i]
        pats = '{3'b000, 3'b010, 3'b100, 3'b001};
        tbl  = '{8'h95, 8'hB2, 8'hA9, 8'hD5};
        rst = 1; stall = 0; flush = 0;
        alu_valid = 1; alu_op = 3'b000; alu_flag = 3'b111;
        br_valid = 1; br_cond = 3'b111; br_reg_mode = 0;
        pc_plus2 = 16'h0100; br_imm = 9'h004; br_reg = 16'h0;
        step(); step();
        rst = 0; idle();
        chk("rst_flags", 16'(flags), 16'h0);
        chk("rst_valid", 16'(br_out_valid), 16'h0);
        chk("rst_taken", 16'(br_taken), 16'h0);
        chk("rst_target", br_target, 16'h0);

        alu_valid = 1; alu_op = 3'b000; alu_flag = 3'b101; step();
        chk("mask_add", 16'(flags), 16'h5);
        alu_op = 3'b100; alu_flag = 3'b010; step();
        chk("mask_sll", 16'(flags), 16'h7);
        alu_op = 3'b111; alu_flag = 3'b000; step();
        chk("mask_paddsb", 16'(flags), 16'h7);
        idle();

        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_op = 3'b000; alu_flag = pats[i]; step();
            alu_valid = 0;
            for (int c = 0; c < 8; c++) begin
                br_valid = 1; br_cond = 3'(c); step();
                br_valid = 0;
                chk($sformatf("cond%0d_p%0d_valid", c, i), 16'(br_out_valid), 16'h1);
                chk($sformatf("cond%0d_p%0d_taken", c, i), 16'(br_taken), 16'(tbl[i][c]));
                step();
                chk($sformatf("cond%0d_p%0d_pulse", c, i), 16'(br_out_valid), 16'h0);
                chk($sformatf("cond%0d_p%0d_taken0", c, i), 16'(br_taken), 16'h0);
            end
        end

        br_valid = 1; br_cond = 3'b111; br_reg_mode = 0; pc_plus2 = 16'hFFFE; br_imm = 9'h001; step();
        chk("b_wrap_target", br_target, 16'h0000);
        chk("b_wrap_valid", 16'(br_out_valid), 16'h1);
        pc_plus2 = 16'h0400; br_imm = 9'h100; step();
        chk("b_neg_target", br_target, 16'h0200);
        br_reg_mode = 1; br_reg = 16'h1234; step();
        chk("br_target", br_target, 16'h1234);
        chk("br_taken", 16'(br_taken), 16'h1);

        stall = 1; br_reg = 16'h5555; alu_valid = 1; alu_op = 3'b000; alu_flag = 3'b110;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", 16'(br_out_valid), 16'h1);
            chk("stall_taken", 16'(br_taken), 16'h1);
            chk("stall_target", br_target, 16'h1234);
            chk("stall_flags", 16'(flags), 16'h1);
        end

        stall = 0; flush = 1; br_reg = 16'h7777; step();
        chk("flush_valid", 16'(br_out_valid), 16'h0);
        chk("flush_taken", 16'(br_taken), 16'h0);
        chk("flush_target", br_target, 16'h1234);
        chk("flush_flags", 16'(flags), 16'h1);
        flush = 0; alu_valid = 0; br_reg = 16'h4321; step();
        chk("post_flush_target", br_target, 16'h4321);
        flush = 1; stall = 1; br_reg = 16'h9999; step();
        chk("flush_stall_valid", 16'(br_out_valid), 16'h0);
        chk("flush_stall_taken", 16'(br_taken), 16'h0);
        chk("flush_stall_target", br_target, 16'h4321);
        idle();

        alu_valid = 1; alu_op = 3'b000; alu_flag = 3'b000; step();
        chk("fwd_pre_flags", 16'(flags), 16'h0);
        alu_op = 3'b001; alu_flag = 3'b010; br_valid = 1; br_cond = 3'b001; step();
`ifdef FLAG_FWD_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        chk("fwd_taken", 16'(br_taken), 16'(exp_fwd));
        chk("fwd_flags", 16'(flags), 16'h2);
        idle(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
